// File: rtl/hash_arbiter_if.sv
// -----------------------------------------------------------------------------
// hash_arbiter_if
//
// Purpose: bundles every handshake and engine signal of hash_arbiter so the
// arbiter and its environment connect through a single port.
//
// Signal summary (direction as seen from the arbiter, modport slave):
//   req0_valid, req1_valid  in   requester has a message pending
//   req0_msg,   req1_msg    in   32-bit message, byte m[0] in [31:24]
//   req0_ready, req1_ready  out  one-cycle accept pulse
//   rsp_valid               out  digest available
//   rsp_ready               in   consumer takes the digest
//   rsp_id                  out  requester that owns the response
//   rsp_digest              out  32-bit digest, byte d[0] in [31:24]
//   rsp_err                 out  engine timeout flag
//   busy                    out  block is not idle
//   eng_start               out  start pulse to the shared hash engine
//   eng_m                   out  message driven to the engine
//   eng_done                in   engine one-cycle done pulse
//   eng_d                   in   engine digest, valid with eng_done
//
// Modport master is the environment side (requesters, consumer, engine).
// -----------------------------------------------------------------------------
interface hash_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_msg;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_msg;
    logic        req1_ready;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_digest;
    logic        rsp_err;

    logic        busy;

    logic        eng_start;
    logic [31:0] eng_m;
    logic        eng_done;
    logic [31:0] eng_d;

    modport slave (
        input  req0_valid, req0_msg, req1_valid, req1_msg,
        input  rsp_ready, eng_done, eng_d,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_digest, rsp_err,
        output busy, eng_start, eng_m
    );

    modport master (
        output req0_valid, req0_msg, req1_valid, req1_msg,
        output rsp_ready, eng_done, eng_d,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_digest, rsp_err,
        input  busy, eng_start, eng_m
    );
endinterface

// File: rtl/hash_arbiter.sv
// -----------------------------------------------------------------------------
// hash_arbiter
//
// Purpose: shares one hash engine between two requesters. A round-robin
// arbiter accepts one message at a time, issues it to the engine, waits for
// the digest and presents it on a valid/ready response channel tagged with
// the owning requester.
//
// Ports:
//   clk   in   single clock, rising edge
//   rst   in   asynchronous reset, active high
//   bus   hash_arbiter_if.slave  requests, response and engine signals
//
// Parameters:
//   TIMEOUT_CYCLES  maximum cycles spent waiting for the engine (timeout
//                   build only)
//
// Build option:
//   HASH_ARB_TIMEOUT_EN  when defined, WAIT is bounded by TIMEOUT_CYCLES and
//                        an expiry returns rsp_err=1 with a zero digest. When
//                        undefined there is no counter, rsp_err is tied low
//                        and WAIT lasts until eng_done.
// -----------------------------------------------------------------------------
module hash_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    hash_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // A zero timeout would leave no cycle for the engine to answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("hash_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q, state_d;
    logic [31:0] msg_q, msg_d;       // message latched at grant, feeds eng_m
    logic        id_q, id_d;         // owner of the transaction in flight
    logic        last_q, last_d;     // requester served most recently
    logic [31:0] digest_q, digest_d;

    logic any_req;
    logic both_req;
    logic grant_id;
    logic grant0;
    logic grant1;
    logic eng_start_c;

`ifdef HASH_ARB_TIMEOUT_EN
    localparam int unsigned   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // The counter reads 0 in the first WAIT cycle, so the last allowed cycle
    // is the one where it reads TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             expired;

    assign expired = (cnt_q == CNT_LAST);
`endif

    // Round robin: on contention the requester not served last wins; a lone
    // request wins regardless of the pointer.
    assign any_req  = bus.req0_valid | bus.req1_valid;
    assign both_req = bus.req0_valid & bus.req1_valid;
    assign grant_id = both_req ? ~last_q : bus.req1_valid;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        msg_d       = msg_q;
        id_d        = id_q;
        last_d      = last_q;
        digest_d    = digest_q;
        grant0      = 1'b0;
        grant1      = 1'b0;
        eng_start_c = 1'b0;
`ifdef HASH_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant0  = ~grant_id;
                    grant1  = grant_id;
                    msg_d   = grant_id ? bus.req1_msg : bus.req0_msg;
                    id_d    = grant_id;
                    last_d  = grant_id;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                eng_start_c = 1'b1;
`ifdef HASH_ARB_TIMEOUT_EN
                cnt_d       = '0;
`endif
                state_d     = WAIT;
            end

            WAIT: begin
                // eng_done is checked first so it wins over a same-cycle
                // expiry.
                if (bus.eng_done) begin
                    digest_d = bus.eng_d;
`ifdef HASH_ARB_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = RESP;
                end
`ifdef HASH_ARB_TIMEOUT_EN
                else if (expired) begin
                    digest_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                end
`endif
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the pointer resets to 1 so requester 0 wins the first
        // contention; everything else resets to zero.
        if (rst) begin
            state_q  <= IDLE;
            msg_q    <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            digest_q <= '0;
`ifdef HASH_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q  <= state_d;
            msg_q    <= msg_d;
            id_q     <= id_d;
            last_q   <= last_d;
            digest_q <= digest_d;
`ifdef HASH_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // The accept pulse is combinational in IDLE; gating with rst keeps it low
    // while reset is held even if a request is pending.
    assign bus.req0_ready = grant0 & ~rst;
    assign bus.req1_ready = grant1 & ~rst;

    assign bus.eng_start  = eng_start_c;
    assign bus.eng_m      = msg_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_digest = digest_q;
    assign bus.busy       = (state_q != IDLE);

`ifdef HASH_ARB_TIMEOUT_EN
    assign bus.rsp_err    = err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_hash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hash_arbiter
//
// Directed self-checking bench for hash_arbiter. A behavioural engine answers
// each eng_start after a programmable number of cycles with a digest that is a
// fixed function of the message. Expected responses are queued at grant time
// and popped when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_hash_arbiter;

    localparam int TO = 8;
`ifdef HASH_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_arbiter_if bus ();

    hash_arbiter #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] digest;
        logic        err;
    } rsp_t;

    rsp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine digest: half-word swap xor key; maps 32'h01020304 to 32'hDEADBEEF.
    function automatic logic [31:0] eng_fn(input logic [31:0] m);
        return {m[15:0], m[31:16]} ^ 32'hDDA9BFED;
    endfunction

    // ---------------- engine model ----------------
    int          eng_delay = 0;   // <= 0 means the engine never answers
    int          eng_cnt   = 0;
    logic [31:0] eng_msg   = '0;

    initial begin
        bus.eng_done = 1'b0;
        bus.eng_d    = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.eng_done = 1'b0;
            bus.eng_d    = ~eng_fn(eng_msg);
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_d    = eng_fn(eng_msg);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.eng_start === 1'b1 && eng_delay > 0) begin
                eng_cnt = eng_delay;
                eng_msg = bus.eng_m;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"},  {30'h0, bus.req0_ready, bus.req1_ready}, 32'h0);
        check({tag, "_flags"},  {27'h0, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                                 bus.busy, bus.eng_start}, 32'h0);
        check({tag, "_digest"}, bus.rsp_digest, 32'h0);
        check({tag, "_eng_m"},  bus.eng_m, 32'h0);
    endtask

    // One complete transaction starting in IDLE. keep_other leaves the losing
    // request asserted so it is served by the following call.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [31:0] m0, input logic [31:0] m1,
                           input logic exp_id, input int delay,
                           input logic keep_other, input int bp);
        logic [31:0] exp_msg;
        logic        exp_err;
        int          exp_lat;
        int          acc;
        int          n;
        logic        stray;
        rsp_t        e;

        exp_err = TMO_EN && (delay <= 0 || delay > TO);
        exp_lat = exp_err ? TO + 2 : delay + 2;
        exp_msg = exp_id ? m1 : m0;

        eng_delay      = delay;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_msg   = m0;
        bus.req1_msg   = m1;
        #1;
        check("grant_ready0", bus.req0_ready, !exp_id);
        check("grant_ready1", bus.req1_ready, exp_id);
        sb.push_back('{exp_id, exp_err ? 32'h0 : eng_fn(exp_msg), exp_err});
        acc = cyc;

        tick();
        if (exp_id) bus.req1_valid = 1'b0;
        else        bus.req0_valid = 1'b0;
        if (!keep_other) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        #1;
        check("issue_start", bus.eng_start, 1);
        check("issue_eng_m", bus.eng_m, exp_msg);
        check("issue_busy",  bus.busy, 1);
        check("issue_ready", {bus.req0_ready, bus.req1_ready}, 0);

        tick();
        check("start_pulse", bus.eng_start, 0);

        n     = 0;
        stray = 1'b0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            if (bus.req0_ready | bus.req1_ready) stray = 1'b1;
            tick();
            n++;
        end
        check("rsp_arrive",  bus.rsp_valid, 1);
        check("rsp_latency", 32'(cyc - acc), 32'(exp_lat));
        check("wait_ready",  stray, 0);
        check("resp_eng_m",  bus.eng_m, exp_msg);

        e = sb.pop_front();
        check("rsp_id",     bus.rsp_id, e.id);
        check("rsp_digest", bus.rsp_digest, e.digest);
        check("rsp_err",    bus.rsp_err, e.err);

        repeat (bp) begin
            tick();
            check("bp_valid",  bus.rsp_valid, 1);
            check("bp_id",     bus.rsp_id, e.id);
            check("bp_digest", bus.rsp_digest, e.digest);
            check("bp_err",    bus.rsp_err, e.err);
            check("bp_ready",  {bus.req0_ready, bus.req1_ready}, 0);
        end

        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_drop",  bus.rsp_valid, 0);
        check("idle_busy", bus.busy, 0);

        // Let a late answer from a timed-out job drain while idle.
        n = 0;
        while (eng_cnt != 0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int   n;
        logic seen;

        bus.req0_valid = 1'b1;   // pending during reset: must not be accepted
        bus.req0_msg   = 32'h11111111;
        bus.req1_valid = 1'b0;
        bus.req1_msg   = 32'h0;
        bus.rsp_ready  = 1'b0;
        #2;
        check_zero_outputs("reset");
        tick();
        tick();
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single request with the reference latency.
        run_txn(1'b1, 1'b0, 32'h01020304, 32'h0, 1'b0, 26, 1'b0, 0);

        // Contention after reset: 0, then the waiting 1, then 0 again.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_txn(1'b1, 1'b1, 32'hA0A1A2A3, 32'hB0B1B2B3, 1'b0, 5, 1'b1, 10);
        run_txn(1'b0, 1'b1, 32'hA0A1A2A3, 32'hB0B1B2B3, 1'b1, 6, 1'b0, 0);
        run_txn(1'b1, 1'b1, 32'hC0C1C2C3, 32'hD0D1D2D3, 1'b0, 3, 1'b0, 0);

        // Lone requests win regardless of the pointer; pointer still advances.
        run_txn(1'b0, 1'b1, 32'h0, 32'h12345678, 1'b1, 4, 1'b0, 2);
        run_txn(1'b0, 1'b1, 32'h0, 32'h9ABCDEF0, 1'b1, 2, 1'b0, 0);
        run_txn(1'b1, 1'b1, 32'h55AA55AA, 32'hAA55AA55, 1'b0, 7, 1'b0, 1);

        // A request that withdraws while the block is busy gets no grant.
        fork
            run_txn(1'b1, 1'b0, 32'h0BADF00D, 32'h0, 1'b0, 7, 1'b0, 0);
            begin
                repeat (3) tick();
                bus.req1_valid = 1'b1;
                bus.req1_msg   = 32'hFEEDFACE;
                repeat (2) tick();
                bus.req1_valid = 1'b0;
            end
        join
        seen = 1'b0;
        repeat (3) begin
            if (bus.req0_ready | bus.req1_ready | bus.busy) seen = 1'b1;
            tick();
        end
        check("withdrawn_no_grant", seen, 0);

        // Reset five cycles after eng_start; the late eng_done is ignored.
        eng_delay      = 10;
        bus.req0_valid = 1'b1;
        bus.req0_msg   = 32'hCAFE0001;
        #1;
        check("abort_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        check("abort_start", bus.eng_start, 1);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check_zero_outputs("abort");
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        n    = 0;
        repeat (20) begin
            if (bus.rsp_valid | bus.busy) seen = 1'b1;
            tick();
            n++;
        end
        check("abort_no_rsp", seen, 0);

        // Pointer restored by reset: requester 0 wins again.
        run_txn(1'b1, 1'b1, 32'h13579BDF, 32'h2468ACE0, 1'b0, 4, 1'b0, 0);

`ifdef HASH_ARB_TIMEOUT_EN
        // Engine never answers, then answers on the last allowed cycle.
        run_txn(1'b1, 1'b0, 32'h0F0F0F0F, 32'h0, 1'b0, -1, 1'b0, 0);
        run_txn(1'b1, 1'b0, 32'h87654321, 32'h0, 1'b0, TO, 1'b0, 0);
`else
        // Without the timeout option the block waits as long as it takes.
        run_txn(1'b1, 1'b0, 32'h0F0F0F0F, 32'h0, 1'b0, 40, 1'b0, 0);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hash_arbiter.md
HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum engine wait in cycles (used only with HASH_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester has a message pending.
REQ-005 SHALL have ports req0_msg / req1_msg  input  32 each  message bytes m[0..3], where m[0] is bits [31:24].
REQ-006 SHALL have ports req0_ready / req1_ready  output  1 each  one-cycle accept pulse.
REQ-007 SHALL have port rsp_valid  output  1  digest available.
REQ-008 SHALL have port rsp_ready  input  1  consumer takes the digest.
REQ-009 SHALL have port rsp_id  output  1  requester that owns the response.
REQ-010 SHALL have port rsp_digest  output  32  digest bytes d[0..3], where d[0] is bits [31:24].
REQ-011 SHALL have port rsp_err  output  1  engine timeout flag.
REQ-012 SHALL have port busy  output  1  high whenever the block is not in IDLE.
REQ-013 SHALL have port eng_start  output  1  start pulse to the shared hash engine.
REQ-014 SHALL have port eng_m  output  32  message driven to the engine.
REQ-015 SHALL have port eng_done  input  1  engine one-cycle done pulse.
REQ-016 SHALL have port eng_d  input  32  engine digest, valid in the eng_done cycle.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-018 In IDLE, if any reqN_valid is high, SHALL assert the granted reqN_ready combinationally in that cycle, register its msg and id, and go to ISSUE.
REQ-019 SHALL arbitrate round-robin: with both requests valid, grant the requester not served last; with one valid, grant that one.
REQ-020 SHALL update the last-served pointer only when a grant occurs.
REQ-021 In ISSUE, SHALL assert eng_start for exactly one cycle and then go to WAIT.
REQ-022 SHALL hold eng_m at the registered message from ISSUE until the block returns to IDLE.
REQ-023 In WAIT, on eng_done, SHALL capture eng_d into rsp_digest and go to RESP.
REQ-024 In RESP, SHALL hold rsp_valid high with rsp_id, rsp_digest and rsp_err stable until rsp_ready is high.
REQ-025 A cycle in RESP with rsp_ready high SHALL return the block to IDLE, with rsp_valid low in the next cycle.
REQ-026 Outside IDLE, SHALL keep both reqN_ready low; pending requests wait and are not dropped by the arbiter.
REQ-027 A requester dropping valid before its grant SHALL get no grant; this is a legal condition.
REQ-028 SHALL ignore eng_done in any state other than WAIT.
REQ-029 Latency SHALL be: accept at cycle 0, eng_start at cycle 1, rsp_valid one cycle after eng_done.

Reset
REQ-030 On rst high, SHALL asynchronously force state to IDLE.
REQ-031 On rst high, SHALL force to 0: all outputs, the registered msg/id, and the timeout counter.
REQ-032 On rst high, SHALL set the last-served pointer to 1, so requester 0 wins the first contention.
REQ-033 Reset during ISSUE, WAIT or RESP SHALL abort the transaction with no response.
REQ-034 A later eng_done from the aborted job SHALL be ignored per REQ-028.

Configuration
REQ-035 With macro HASH_ARB_TIMEOUT_EN defined, SHALL count cycles in WAIT.
REQ-036 With HASH_ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES without eng_done, SHALL go to RESP with rsp_err=1 and rsp_digest=32'h0.
REQ-037 With HASH_ARB_TIMEOUT_EN defined, if eng_done and count expiry fall in the same cycle, eng_done SHALL win and rsp_err SHALL be 0.
REQ-038 With HASH_ARB_TIMEOUT_EN undefined, SHALL tie rsp_err to 0, include no counter, and wait in WAIT indefinitely.

Verification
REQ-039 Single request: req0 with msg 32'h01020304; engine model returns done after 26 cycles with d=32'hDEADBEEF -> req0_ready at cycle 0, eng_start at cycle 1, eng_m=32'h01020304, rsp_valid at cycle 28 with rsp_id=0 and rsp_digest=32'hDEADBEEF.
REQ-040 Contention: req0 and req1 both valid after reset -> req0 is served first and req1 second; third contention -> req0.
REQ-041 Backpressure: rsp_ready held low for 10 cycles -> rsp_valid and all response fields stable; no new grant while req1 is valid.
REQ-042 Mid-WAIT reset: rst pulsed 5 cycles after eng_start -> all outputs 0; a later eng_done produces no rsp_valid.
REQ-043 Timeout with HASH_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, engine never done -> rsp_valid with rsp_err=1 and rsp_digest=0.
REQ-044 Same build, eng_done exactly on the 8th WAIT cycle -> rsp_err=0 and rsp_digest equals eng_d.
